adc_capture_ctrl: RTL

//  Parametrised ADC-to-DPRAM capture engine writing packed adc_sample_t words into a ring region of the

---
 rtl/signal_types_pkg.sv | 28 ++
 rtl/adc_capture_ctrl_if.sv | 21 ++
 rtl/adc_decim_strobe.sv | 28 ++
 rtl/adc_capture_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/signal_types_pkg.sv
// Shared types for the ADC capture path: the packed sample word plus capture mode/state enums.
package signal_types_pkg;

  typedef struct packed {
    logic [3:0]  channel;
    logic [3:0]  flags;
    logic [23:0] code;
  } adc_sample_t;

  typedef enum logic {
    CAP_SINGLE = 1'b0,
    CAP_RING   = 1'b1
  } cap_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    SINGLE,
    PREFILL,
    ARMED,
    POST,
    DONE
  } cap_state_t;

  function automatic logic is_writing(input cap_state_t s);
    return (s == SINGLE) || (s == PREFILL) || (s == ARMED) || (s == POST);
  endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// ADC sample stream in and DPRAM write port out, bundled for the capture engine.
interface adc_capture_ctrl_if
  import signal_types_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) ();

  adc_sample_t       adc_sample_in;
  logic              adc_valid_i;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [ADDR_W-1:0] mem_addr_o;

  // master = sample source / memory side, slave = capture engine
  modport master (output adc_sample_in, adc_valid_i,
                  input  mem_we_o, mem_data_o, mem_addr_o);
  modport slave  (input  adc_sample_in, adc_valid_i,
                  output mem_we_o, mem_data_o, mem_addr_o);

endinterface

// File: rtl/adc_decim_strobe.sv
// Decimation strobe: marks 1 of every (i_ratio+1) valid samples while enabled, restarting on i_clear.
module adc_decim_strobe #(
  parameter int DECIM_W = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               i_valid,
  input  logic               i_enable,
  input  logic               i_clear,
  input  logic [DECIM_W-1:0] i_ratio,
  output logic               o_accept
);

  logic [DECIM_W-1:0] r_cnt;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && i_valid) begin
      r_cnt <= (r_cnt == i_ratio) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_accept = i_enable && i_valid && (r_cnt == '0);

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC-to-DPRAM capture engine: single-shot or pre-trigger ring capture into a power-of-two region.
module adc_capture_ctrl
  import signal_types_pkg::*;
#(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int BASE_ADDR = 'h400,
  parameter int DEPTH     = 4096,
  parameter int DECIM_W   = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  adc_capture_ctrl_if.slave        mem_if,
  input  logic                     trig_i,
  input  logic                     csr_start_i,
  input  logic                     csr_abort_i,
  input  logic                     csr_mode_i,
  input  logic [DECIM_W-1:0]       csr_decim_i,
  input  logic [$clog2(DEPTH)-1:0] csr_pretrig_i,
  output logic                     csr_busy_o,
  output logic                     csr_done_o,
  output logic [ADDR_W-1:0]        csr_trig_addr_o
);

  localparam int                OFF_W   = $clog2(DEPTH);
  localparam int                CNT_W   = OFF_W + 1;
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);

  cap_state_t         r_state, w_next_state;
  logic               r_start_d, r_trig_d;
  logic [DECIM_W-1:0] r_decim;
  logic [OFF_W-1:0]   r_pretrig;
  logic [OFF_W-1:0]   r_off;
  logic [CNT_W-1:0]   r_count;
  logic               r_trig_pend;
  logic [ADDR_W-1:0]  r_trig_addr;
  logic               r_done;
  logic               r_we;
  logic [DATA_W-1:0]  r_data;
  logic [ADDR_W-1:0]  r_addr;

  logic               w_start_edge, w_trig_edge, w_go, w_trig_hit, w_accept;
  logic [CNT_W-1:0]   w_post_total;

  assign w_start_edge = csr_start_i && !r_start_d;
  assign w_trig_edge  = trig_i && !r_trig_d;
  assign w_post_total = DEPTH_C - {1'b0, r_pretrig};

  adc_decim_strobe #(.DECIM_W(DECIM_W)) u_decim (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_valid   (mem_if.adc_valid_i),
    .i_enable  (is_writing(r_state)),
    .i_clear   (w_go),
    .i_ratio   (r_decim),
    .o_accept  (w_accept)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) r_state <= IDLE;
    else            r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_go         = 1'b0;
    w_trig_hit   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_edge) begin
          w_go = 1'b1;
          if (cap_mode_t'(csr_mode_i) == CAP_SINGLE) w_next_state = SINGLE;
          else if (csr_pretrig_i != '0)              w_next_state = PREFILL;
          else                                       w_next_state = ARMED;
        end
      end
      SINGLE:  if (w_accept && r_count == DEPTH_C - ONE_C) w_next_state = DONE;
      PREFILL: if (w_accept && r_count + ONE_C == {1'b0, r_pretrig}) w_next_state = ARMED;
      ARMED: begin
        // a trigger edge coinciding with an accepted sample makes that sample the trigger sample
        if (w_accept && (r_trig_pend || w_trig_edge)) begin
          w_trig_hit   = 1'b1;
          w_next_state = (w_post_total == ONE_C) ? DONE : POST;
        end
      end
      POST:    if (w_accept && r_count == w_post_total - ONE_C) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (csr_abort_i) begin
      w_next_state = IDLE;
      w_go         = 1'b0;
      w_trig_hit   = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_start_d   <= 1'b0;
      r_trig_d    <= 1'b0;
      r_decim     <= '0;
      r_pretrig   <= '0;
      r_off       <= '0;
      r_count     <= '0;
      r_trig_pend <= 1'b0;
      r_trig_addr <= BASE;
      r_done      <= 1'b0;
      r_we        <= 1'b0;
      r_data      <= '0;
      r_addr      <= BASE;
    end else begin
      r_start_d <= csr_start_i;
      r_trig_d  <= trig_i;
      r_we      <= w_accept && !csr_abort_i;
      if (w_accept) begin
        r_data <= DATA_W'(mem_if.adc_sample_in);
        r_addr <= BASE + ADDR_W'(r_off);
      end
      if (w_go) begin
        r_decim     <= csr_decim_i;
        r_pretrig   <= csr_pretrig_i;
        r_off       <= '0;
        r_count     <= '0;
        r_trig_pend <= 1'b0;
        r_trig_addr <= BASE;
        r_done      <= 1'b0;
      end else begin
        if (w_accept) begin
          r_off <= r_off + 1'b1;
          // r_count restarts per phase: pre-trigger fill, then post-trigger including the trigger sample
          if (r_state == PREFILL && w_next_state == ARMED) r_count <= '0;
          else if (w_trig_hit)                             r_count <= ONE_C;
          else                                             r_count <= r_count + ONE_C;
        end
        if (w_trig_hit) begin
          r_trig_addr <= BASE + ADDR_W'(r_off);
          r_trig_pend <= 1'b0;
        end else if (r_state == ARMED && w_trig_edge && !csr_abort_i) begin
          r_trig_pend <= 1'b1;
        end
        if (w_next_state == DONE) r_done <= 1'b1;
      end
    end
  end

  assign csr_busy_o        = is_writing(r_state);
  assign csr_done_o        = r_done;
  assign csr_trig_addr_o   = r_trig_addr;
  assign mem_if.mem_we_o   = r_we;
  assign mem_if.mem_data_o = r_data;
  assign mem_if.mem_addr_o = r_addr;

endmodule
